pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 4-stage IF/ID/EX/MEM core.
- Generates the per-stage stall and flush signals from bus-busy, load-hazard and exception events.
- Owns the control-register file read by the ID decoder over CRegRdAddr/CRegRdData, and written by MEM-stage control ops.
- Sequences exception entry, interrupt entry and exception return through a small FSM, and supplies the redirect PC (NewPC) to IF.

Parameters:
- ADDR_W, 30, word-address width of PCs and vectors.
- DATA_W, 32, control-register data width.
- CODE_W, 3, exception-code width.

Ports:
- clk  in  1  clock
- reset_  in  1  synchronous reset, active-high
- IFBusy  in  1  instruction bus not ready
- MemBusy  in  1  data bus not ready
- LDHazard  in  1  load-use hazard flagged by ID
- IRQ  in  1  external interrupt, level
- MemEn  in  1  MEM stage holds a valid instruction
- MemPC  in  ADDR_W  PC of the MEM-stage instruction
- MemCtrlOp  in  2  0 NOP, 1 WRCR, 2 EXRT, 3 reserved (NOP)
- MemExpCode  in  CODE_W  0 none, nonzero = exception cause
- MemWrAddr  in  5  control-register write address
- MemWrData  in  DATA_W  control-register write data
- CRegRdAddr  in  5  ID read address
- CRegRdData  out  DATA_W  combinational read data
- ExeMode  out  1  0 kernel, 1 user
- IntEn  out  1  interrupt enable
- IFStall, IDStall, EXStall, MemStall  out  1 each  stage hold
- IFFlush, IDFlush, EXFlush, MemFlush  out  1 each  stage squash
- NewPC  out  ADDR_W  redirect target, valid while IFFlush=1

Behaviour:
- Control registers:
  - 0 STATUS: bit0 ExeMode, bit1 IntEn.
  - 1 PRE_STATUS.
  - 2 EPC: ADDR_W bits, zero-extended on read.
  - 3 EXP_VEC.
  - 4 CAUSE: low CODE_W bits.
  - All other addresses read 0; writes to them are ignored.
- Reset: STATUS=0 (kernel mode, interrupts off). PRE_STATUS, EPC, EXP_VEC, CAUSE = 0. FSM = RUN. All stall and flush outputs 0. NewPC=0.
- CRegRdData is combinational. A write in the same cycle is not bypassed; ID receives the old value.
- Stalls:
  - Any of IFBusy/MemBusy = 1 → all four stall outputs 1.
  - Otherwise LDHazard = 1 → IFStall=IDStall=1 and EXFlush=1 (bubble into EX).
  - Stall has priority over LDHazard handling. No register updates happen while stalled.
- Event detection happens only in RUN, only when MemEn=1, and only when not stalled. Priority:
  1. MemExpCode≠0 → trap, cause = MemExpCode.
  2. IntEn & IRQ → trap, cause = 7 (interrupt).
  3. MemCtrlOp=EXRT → return.
  4. MemCtrlOp=WRCR → register write at the clock edge, no flush.
- Trap, in the detect cycle (edge t):
  - PRE_STATUS ← STATUS, EPC ← MemPC, CAUSE ← cause.
  - STATUS ← {IntEn=0, ExeMode=0}.
  - FSM → REDIRECT.
  - All four flush outputs are combinationally 1 in the detect cycle.
  - NewPC = EXP_VEC.
- Return, in the detect cycle:
  - STATUS ← PRE_STATUS.
  - All flushes = 1, NewPC = EPC.
  - FSM → REDIRECT.
- REDIRECT (exactly 1 cycle):
  - IDFlush=EXFlush=MemFlush=1, IFFlush=0.
  - No events are detected. Stall inputs are still honoured.
  - FSM → RUN unconditionally.
- ExeMode and IntEn are always equal to STATUS bits, registered.
- IRQ while IntEn=0 is ignored and not latched.
- reset_ asserted in any state forces RUN and the reset values on the next edge.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined:
  - Adds a 32-bit STALLCNT at control-register address 5.
  - Increments on every cycle where IFStall=1, saturating at 0xFFFFFFFF.
  - Reset value 0. WRCR to address 5 loads MemWrData.
- When undefined: address 5 reads 0 and no counter logic exists.

Test Plan:
- Reset then idle, MemEn=1, MemCtrlOp=0 → all stalls/flushes 0, CRegRdData(addr0)=0, ExeMode=0, IntEn=0.
- WRCR addr3 data 0x100, then WRCR addr0 data 3 → EXP_VEC=0x100, ExeMode=1, IntEn=1. Read of addr0 in the write cycle returns the old value 0.
- LDHazard=1 for 1 cycle → IFStall=IDStall=1, EXFlush=1, MEM signals 0. With MemBusy=1 in the same cycle → all stalls 1, EXFlush=0.
- MemExpCode=2, MemPC=0x40 with STATUS=3 → same-cycle all flushes 1, NewPC=0x100. Next cycle: EPC=0x40, CAUSE=2, PRE_STATUS=3, STATUS=0, ID/EX/MEM flush 1, IFFlush 0. Then RUN.
- EXRT after the trap above → NewPC=0x40, STATUS restored to 3.
- IRQ=1 and IntEn=1 while MemBusy=1 → no trap. When MemBusy drops → trap with CAUSE=7. IRQ=1 with IntEn=0 → no action.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the IF/ID/EX/MEM core: stall/flush generation, control registers,
// trap/return sequencing. Optional stall counter at CR address 5 under `PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              IFBusy,
    input  logic              MemBusy,
    input  logic              LDHazard,
    input  logic              IRQ,
    input  logic              MemEn,
    input  logic [ADDR_W-1:0] MemPC,
    input  logic [1:0]        MemCtrlOp,
    input  logic [CODE_W-1:0] MemExpCode,
    input  logic [4:0]        MemWrAddr,
    input  logic [DATA_W-1:0] MemWrData,
    input  logic [4:0]        CRegRdAddr,
    output logic [DATA_W-1:0] CRegRdData,
    output logic              ExeMode,
    output logic              IntEn,
    output logic              IFStall,
    output logic              IDStall,
    output logic              EXStall,
    output logic              MemStall,
    output logic              IFFlush,
    output logic              IDFlush,
    output logic              EXFlush,
    output logic              MemFlush,
    output logic [ADDR_W-1:0] NewPC
);

    typedef enum logic {ST_RUN, ST_REDIRECT} state_t;

    localparam logic [CODE_W-1:0] IRQ_CAUSE = CODE_W'(7);
    localparam logic [1:0]        OP_WRCR   = 2'd1;
    localparam logic [1:0]        OP_EXRT   = 2'd2;

    state_t              state_reg, state_next;
    logic [1:0]          status_reg;      // bit0 ExeMode, bit1 IntEn
    logic [1:0]          pre_status_reg;
    logic [ADDR_W-1:0]   epc_reg;
    logic [DATA_W-1:0]   exp_vec_reg;
    logic [CODE_W-1:0]   cause_reg;

    logic                bus_stall, detect, exp_hit, irq_hit;
    logic                do_trap, do_return, do_wrcr;
    logic [CODE_W-1:0]   trap_cause;

    always_comb begin
        bus_stall  = IFBusy | MemBusy;
        detect     = (state_reg == ST_RUN) && MemEn && !bus_stall;
        exp_hit    = (MemExpCode != '0);
        irq_hit    = status_reg[1] & IRQ;
        do_trap    = detect && (exp_hit || irq_hit);
        do_return  = detect && !(exp_hit || irq_hit) && (MemCtrlOp == OP_EXRT);
        do_wrcr    = detect && !(exp_hit || irq_hit) && (MemCtrlOp == OP_WRCR);
        trap_cause = exp_hit ? MemExpCode : IRQ_CAUSE;
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        IFStall    = bus_stall | LDHazard;
        IDStall    = bus_stall | LDHazard;
        EXStall    = bus_stall;
        MemStall   = bus_stall;
        IFFlush    = 1'b0;
        IDFlush    = 1'b0;
        EXFlush    = LDHazard & !bus_stall;   // bubble behind a load-use hazard
        MemFlush   = 1'b0;
        NewPC      = '0;
        case (state_reg)
            ST_RUN: begin
                if (do_trap || do_return) begin
                    IFFlush    = 1'b1;
                    IDFlush    = 1'b1;
                    EXFlush    = 1'b1;
                    MemFlush   = 1'b1;
                    NewPC      = do_trap ? exp_vec_reg[ADDR_W-1:0] : epc_reg;
                    state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // IF already fetches from the new PC; squash what sits behind it.
                IDFlush    = 1'b1;
                EXFlush    = 1'b1;
                MemFlush   = 1'b1;
                state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            status_reg     <= '0;
            pre_status_reg <= '0;
            epc_reg        <= '0;
            exp_vec_reg    <= '0;
            cause_reg      <= '0;
        end else if (do_trap) begin
            pre_status_reg <= status_reg;
            epc_reg        <= MemPC;
            cause_reg      <= trap_cause;
            status_reg     <= '0;
        end else if (do_return) begin
            status_reg     <= pre_status_reg;
        end else if (do_wrcr) begin
            case (MemWrAddr)
                5'd0:    status_reg     <= MemWrData[1:0];
                5'd1:    pre_status_reg <= MemWrData[1:0];
                5'd2:    epc_reg        <= MemWrData[ADDR_W-1:0];
                5'd3:    exp_vec_reg    <= MemWrData;
                5'd4:    cause_reg      <= MemWrData[CODE_W-1:0];
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset_) begin
            stall_cnt_reg <= '0;
        end else if (do_wrcr && (MemWrAddr == 5'd5)) begin
            stall_cnt_reg <= 32'(MemWrData);
        end else if (IFStall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end
`endif

    // Read port sees register state only; a same-cycle write is not forwarded.
    always_comb begin
        CRegRdData = '0;
        case (CRegRdAddr)
            5'd0:    CRegRdData = DATA_W'(status_reg);
            5'd1:    CRegRdData = DATA_W'(pre_status_reg);
            5'd2:    CRegRdData = DATA_W'(epc_reg);
            5'd3:    CRegRdData = exp_vec_reg;
            5'd4:    CRegRdData = DATA_W'(cause_reg);
`ifdef PIPE_CTRL_PERF_EN
            5'd5:    CRegRdData = DATA_W'(stall_cnt_reg);
`endif
            default: CRegRdData = '0;
        endcase
    end

    assign ExeMode = status_reg[0];
    assign IntEn   = status_reg[1];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus randomized traffic compared each cycle
// against a register-array model of the controller.
`timescale 1ns/1ps
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset_ = 1'b1;
    logic        IFBusy, MemBusy, LDHazard, IRQ, MemEn;
    logic [29:0] MemPC;
    logic [1:0]  MemCtrlOp;
    logic [2:0]  MemExpCode;
    logic [4:0]  MemWrAddr;
    logic [31:0] MemWrData;
    logic [4:0]  CRegRdAddr;
    logic [31:0] CRegRdData;
    logic        ExeMode, IntEn;
    logic        IFStall, IDStall, EXStall, MemStall;
    logic        IFFlush, IDFlush, EXFlush, MemFlush;
    logic [29:0] NewPC;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: architectural control registers by address, plus "one redirect cycle pending".
    logic [31:0] m_cr [0:31];
    bit          m_redir;
    logic [31:0] trap_exp [0:3] = '{32'd3, 32'h40, 32'h100, 32'd2};

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .reset_(reset_),
        .IFBusy(IFBusy), .MemBusy(MemBusy), .LDHazard(LDHazard), .IRQ(IRQ),
        .MemEn(MemEn), .MemPC(MemPC), .MemCtrlOp(MemCtrlOp), .MemExpCode(MemExpCode),
        .MemWrAddr(MemWrAddr), .MemWrData(MemWrData),
        .CRegRdAddr(CRegRdAddr), .CRegRdData(CRegRdData),
        .ExeMode(ExeMode), .IntEn(IntEn),
        .IFStall(IFStall), .IDStall(IDStall), .EXStall(EXStall), .MemStall(MemStall),
        .IFFlush(IFFlush), .IDFlush(IDFlush), .EXFlush(EXFlush), .MemFlush(MemFlush),
        .NewPC(NewPC)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 none, 1 trap, 2 return, 3 control-register write
    function automatic int ev_kind();
        if (m_redir || !MemEn || IFBusy || MemBusy) return 0;
        if (MemExpCode != 3'd0 || (m_cr[0][1] && IRQ)) return 1;
        if (MemCtrlOp == 2'd2) return 2;
        if (MemCtrlOp == 2'd1) return 3;
        return 0;
    endfunction

    task automatic model_update();
        int k;
        if (reset_) begin
            for (int i = 0; i < 32; i++) m_cr[i] = 32'd0;
            m_redir = 1'b0;
            return;
        end
        k = ev_kind();
`ifdef PIPE_CTRL_PERF_EN
        begin
            logic ifst;
            ifst = IFBusy | MemBusy | LDHazard;
            if (k == 3 && MemWrAddr == 5'd5) m_cr[5] = MemWrData;
            else if (ifst && m_cr[5] != 32'hFFFF_FFFF) m_cr[5] = m_cr[5] + 32'd1;
        end
`endif
        case (k)
            1: begin
                m_cr[1] = m_cr[0];
                m_cr[2] = {2'b00, MemPC};
                m_cr[4] = (MemExpCode != 3'd0) ? {29'd0, MemExpCode} : 32'd7;
                m_cr[0] = 32'd0;
            end
            2: m_cr[0] = m_cr[1];
            3: begin
                case (MemWrAddr)
                    5'd0, 5'd1: m_cr[MemWrAddr] = MemWrData & 32'h3;
                    5'd2:       m_cr[2] = MemWrData & 32'h3FFF_FFFF;
                    5'd3:       m_cr[3] = MemWrData;
                    5'd4:       m_cr[4] = MemWrData & 32'h7;
                    default:    ;
                endcase
            end
            default: ;
        endcase
        m_redir = (k == 1 || k == 2);
    endtask

    task automatic compare();
        int   k;
        logic stall, f_if, f_rest;
        k      = ev_kind();
        stall  = IFBusy | MemBusy;
        f_if   = (k == 1 || k == 2);
        f_rest = f_if || m_redir;
        chk("rd_data",   CRegRdData, m_cr[CRegRdAddr]);
        chk("exe_mode",  ExeMode,  m_cr[0][0]);
        chk("int_en",    IntEn,    m_cr[0][1]);
        chk("if_stall",  IFStall,  stall | LDHazard);
        chk("id_stall",  IDStall,  stall | LDHazard);
        chk("ex_stall",  EXStall,  stall);
        chk("mem_stall", MemStall, stall);
        chk("if_flush",  IFFlush,  f_if);
        chk("id_flush",  IDFlush,  f_rest);
        chk("ex_flush",  EXFlush,  f_rest || (LDHazard && !stall));
        chk("mem_flush", MemFlush, f_rest);
        if (f_if) chk("new_pc", NewPC, (k == 1) ? m_cr[3][29:0] : m_cr[2][29:0]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_) compare();
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        IFBusy = 0; MemBusy = 0; LDHazard = 0; IRQ = 0; MemEn = 1;
        MemPC = '0; MemCtrlOp = 2'd0; MemExpCode = 3'd0;
        MemWrAddr = 5'd0; MemWrData = 32'd0; CRegRdAddr = 5'd0;
    endtask

    task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
        set_idle();
        MemCtrlOp = 2'd1; MemWrAddr = a; MemWrData = d;
    endtask

    initial begin
        set_idle();
        MemEn = 0;
        repeat (3) tick();
        reset_ = 1'b0;

        // reset state, idle
        set_idle(); #3;
        chk("rst_rd0", CRegRdData, 0); chk("rst_exe", ExeMode, 0); chk("rst_inten", IntEn, 0);
        chk("rst_ifflush", IFFlush, 0); chk("rst_exstall", EXStall, 0);
        tick();

        // WRCR EXP_VEC then STATUS; no read bypass
        wrcr(5'd3, 32'h100); tick();
        wrcr(5'd0, 32'd3); CRegRdAddr = 5'd0; #3;
        chk("wr_nobypass", CRegRdData, 0);
        tick();
        set_idle(); CRegRdAddr = 5'd3; #3;
        chk("exp_vec", CRegRdData, 32'h100); chk("exe_set", ExeMode, 1); chk("inten_set", IntEn, 1);
        chk("model_status", m_cr[0], 32'd3);
        tick();

        // load hazard, then hazard under bus stall
        set_idle(); LDHazard = 1; #3;
        chk("ld_ifstall", IFStall, 1); chk("ld_idstall", IDStall, 1); chk("ld_exflush", EXFlush, 1);
        chk("ld_exstall", EXStall, 0); chk("ld_memstall", MemStall, 0); chk("ld_memflush", MemFlush, 0);
        tick();
        LDHazard = 1; MemBusy = 1; #3;
        chk("bs_ifstall", IFStall, 1); chk("bs_exstall", EXStall, 1); chk("bs_memstall", MemStall, 1);
        chk("bs_exflush", EXFlush, 0);
        tick();

        // exception trap
        set_idle(); MemExpCode = 3'd2; MemPC = 30'h40; #3;
        chk("trap_ifflush", IFFlush, 1); chk("trap_memflush", MemFlush, 1); chk("trap_newpc", NewPC, 32'h100);
        tick();
        set_idle(); #3;
        chk("redir_ifflush", IFFlush, 0); chk("redir_idflush", IDFlush, 1); chk("redir_memflush", MemFlush, 1);
        chk("redir_exe", ExeMode, 0); chk("redir_inten", IntEn, 0); chk("model_epc", m_cr[2], 32'h40);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_idle(); CRegRdAddr = 5'(i + 1); #3;
            chk("trap_reg", CRegRdData, trap_exp[i]);
            tick();
        end

        // exception return
        set_idle(); MemCtrlOp = 2'd2; #3;
        chk("ret_ifflush", IFFlush, 1); chk("ret_newpc", NewPC, 32'h40);
        tick();
        set_idle(); #3;
        chk("ret_exe", ExeMode, 1); chk("ret_inten", IntEn, 1); chk("ret_redir_ifflush", IFFlush, 0);
        tick();

        // interrupt held off by bus stall, then taken; masked IRQ ignored
        set_idle(); IRQ = 1; MemBusy = 1; #3;
        chk("irq_busy_ifflush", IFFlush, 0); chk("irq_busy_memstall", MemStall, 1);
        tick();
        set_idle(); IRQ = 1; CRegRdAddr = 5'd4; #3;
        chk("irq_old_cause", CRegRdData, 2); chk("irq_ifflush", IFFlush, 1); chk("irq_newpc", NewPC, 32'h100);
        tick();
        set_idle(); IRQ = 1; CRegRdAddr = 5'd4; #3;
        chk("irq_cause", CRegRdData, 7); chk("irq_inten", IntEn, 0);
        tick();
        set_idle(); IRQ = 1; #3;
        chk("irq_masked_ifflush", IFFlush, 0); chk("irq_masked_idflush", IDFlush, 0);
        tick();

        // unmapped address, EPC width, counter address
        wrcr(5'd6, 32'hDEAD_BEEF); tick();
        set_idle(); CRegRdAddr = 5'd6; #3; chk("unmapped_rd", CRegRdData, 0); tick();
        wrcr(5'd2, 32'hFFFF_FFFF); tick();
        set_idle(); CRegRdAddr = 5'd2; #3; chk("epc_width", CRegRdData, 32'h3FFF_FFFF); tick();
        wrcr(5'd5, 32'hFFFF_FFFE); tick();
        repeat (3) begin set_idle(); MemBusy = 1; tick(); end
        set_idle(); CRegRdAddr = 5'd5; #3;
`ifdef PIPE_CTRL_PERF_EN
        chk("stallcnt_sat", CRegRdData, 32'hFFFF_FFFF);
`else
        chk("addr5_absent", CRegRdData, 0);
`endif
        tick();

        // randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 4000; n++) begin
            reset_     = ($urandom_range(0, 249) == 0);
            IFBusy     = ($urandom_range(0, 9) == 0);
            MemBusy    = ($urandom_range(0, 9) == 0);
            LDHazard   = ($urandom_range(0, 5) == 0);
            IRQ        = ($urandom_range(0, 3) == 0);
            MemEn      = ($urandom_range(0, 3) != 0);
            MemPC      = 30'($urandom());
            MemCtrlOp  = 2'($urandom_range(0, 3));
            MemExpCode = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            MemWrAddr  = ($urandom_range(0, 7) == 0) ? 5'($urandom()) : 5'($urandom_range(0, 7));
            MemWrData  = $urandom();
            CRegRdAddr = ($urandom_range(0, 7) == 0) ? 5'($urandom()) : 5'($urandom_range(0, 7));
            #3;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
